// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM endpoint with byte lanes, read-after-write forwarding and WAIT_STATES wait cycles.
// Define AHB_SRAM_ERROR_RESP_EN to return a two-cycle ERROR for out-of-range addresses and sizes above word.
module ahb_sram_slave #(
    parameter int ADDR_BITS   = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ahb_sel,
    input  logic [31:0] ahb_addr,
    input  logic [1:0]  ahb_trans,
    input  logic        ahb_write,
    input  logic [2:0]  ahb_size,
    input  logic [31:0] ahb_wdata,
    input  logic        ahb_ready_in,
    output logic [31:0] ahb_rdata,
    output logic        ahb_readyout,
    output logic        ahb_resp
);
    typedef enum logic [1:0] {OKAY, WAIT, ERR1, ERR2} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [3:0]             r_wcnt;
    logic                   r_active;
    logic                   r_write;
    logic [ADDR_BITS-3:0]   r_idx;
    logic [3:0]             r_lanes;
    logic [31:0]            r_mem [2**(ADDR_BITS-2)];

    logic                   w_accept;
    logic                   w_legal;
    logic [ADDR_BITS-3:0]   w_idx;
    logic [3:0]             w_lanes;
    logic [31:0]            w_mask;
    logic [31:0]            w_wword;
    logic                   w_wr_en;
    logic                   w_fwd;
    logic                   w_unused;

    assign w_accept = ahb_sel & ahb_trans[1] & ahb_ready_in;
    assign w_idx    = ahb_addr[ADDR_BITS-1:2];
    assign w_lanes  = (ahb_size == 3'd0) ? 4'b0001 << ahb_addr[1:0] :
                      (ahb_size == 3'd1) ? (ahb_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_mask   = {{8{r_lanes[3]}}, {8{r_lanes[2]}}, {8{r_lanes[1]}}, {8{r_lanes[0]}}};
    assign w_wr_en  = r_active & r_write & (r_state == OKAY);
    assign w_wword  = (r_mem[r_idx] & ~w_mask) | (ahb_wdata & w_mask);
    // A read accepted on the edge that retires a write to the same word sees the merged word.
    assign w_fwd    = w_wr_en & (r_idx == w_idx);
    assign w_unused = ^{ahb_addr[31:ADDR_BITS], ahb_trans[0]};

`ifdef AHB_SRAM_ERROR_RESP_EN
    assign w_legal = ~|ahb_addr[31:ADDR_BITS] & (ahb_size <= 3'd2);
`else
    assign w_legal = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= OKAY;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_accept)
            w_next = !w_legal ? ERR1 : (WAIT_STATES > 0) ? WAIT : OKAY;
        else if (r_state == WAIT)
            w_next = (r_wcnt == 4'd0) ? OKAY : WAIT;
`ifdef AHB_SRAM_ERROR_RESP_EN
        else if (r_state == ERR1)
            w_next = ERR2;
        else if (r_state == ERR2)
            w_next = OKAY;
`endif
    end

    always_comb begin
        ahb_readyout = (r_state != WAIT) && (r_state != ERR1);
`ifdef AHB_SRAM_ERROR_RESP_EN
        ahb_resp = (r_state == ERR1) || (r_state == ERR2);
`else
        ahb_resp = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wcnt    <= 4'd0;
            r_active  <= 1'b0;
            r_write   <= 1'b0;
            r_idx     <= '0;
            r_lanes   <= 4'd0;
            ahb_rdata <= 32'd0;
        end else begin
            if (w_accept && w_legal)
                r_wcnt <= (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
            else if (r_wcnt != 4'd0)
                r_wcnt <= r_wcnt - 4'd1;
            if (ahb_readyout)
                r_active <= w_accept & w_legal;
            if (w_accept) begin
                r_write   <= ahb_write;
                r_idx     <= w_idx;
                r_lanes   <= w_lanes;
                ahb_rdata <= !w_legal ? 32'd0 : w_fwd ? w_wword : r_mem[w_idx];
            end
        end
    end

    // The array has no reset so its contents survive reset_n.
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_idx] <= w_wword;
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: scoreboard bench driving a zero-wait and a three-wait ahb_sram_slave on one bus.
module tb_ahb_sram_slave;
    logic        clk = 0;
    logic        reset_n = 0;
    logic        sel0 = 0, sel1 = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [1:0]  trans = 0;
    logic        write = 0;
    logic [2:0]  size = 0;
    logic [31:0] rd0, rd1;
    logic        ro0, ro1, rs0, rs1;
    logic        owner = 0, owner_n = 0;
    wire         ready_in = owner ? ro1 : ro0;
    wire  [31:0] rdata_m  = owner ? rd1 : rd0;
    wire         resp_m   = owner ? rs1 : rs0;

    typedef struct { bit rd; logic [31:0] data; bit resp; int waits; } exp_t;
    exp_t q[$];
    exp_t mon_e;
    bit   dp_valid = 0;
    int   waits = 0;
    int   checks = 0, passes = 0;

    always #5 clk = ~clk;

    ahb_sram_slave #(.ADDR_BITS(12), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .ahb_sel(sel0), .ahb_addr(addr), .ahb_trans(trans),
        .ahb_write(write), .ahb_size(size), .ahb_wdata(wdata), .ahb_ready_in(ready_in),
        .ahb_rdata(rd0), .ahb_readyout(ro0), .ahb_resp(rs0));

    ahb_sram_slave #(.ADDR_BITS(12), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .ahb_sel(sel1), .ahb_addr(addr), .ahb_trans(trans),
        .ahb_write(write), .ahb_size(size), .ahb_wdata(wdata), .ahb_ready_in(ready_in),
        .ahb_rdata(rd1), .ahb_readyout(ro1), .ahb_resp(rs1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: retires one expected entry per completed data phase.
    always @(negedge clk) begin
        if (!reset_n) begin
            dp_valid = 0;
            waits = 0;
            q.delete();
        end else begin
            if (dp_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL sb_empty: data phase with no expected entry");
                end else if (!ready_in) begin
                    waits++;
                    chk("wait_resp", 32'(resp_m), 32'(q[0].resp));
                    if (q[0].rd) chk("wait_rdata", rdata_m, q[0].data);
                end else begin
                    mon_e = q.pop_front();
                    chk("waits", 32'(waits), 32'(mon_e.waits));
                    chk("resp", 32'(resp_m), 32'(mon_e.resp));
                    if (mon_e.rd) chk("rdata", rdata_m, mon_e.data);
                    waits = 0;
                end
            end
            if (ready_in) begin
                dp_valid = (sel0 | sel1) & trans[1];
                if (dp_valid) owner_n = sel1;
            end
        end
    end

    always @(posedge clk) owner <= owner_n;

    task automatic issue(input bit s, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] wd, input bit rd_chk, input logic [31:0] ed,
                         input bit er, input int ew);
        int n = 0;
        q.push_back('{rd_chk, ed, er, ew});
        sel0 = !s; sel1 = s; addr = a; trans = 2'b10; write = wr; size = sz;
        do begin @(negedge clk); n++; end while (!ready_in && n < 64);
        if (!ready_in) begin
            checks++;
            $display("FAIL accept_timeout: ready_in stayed 0 for %0d cycles, required 1", n);
        end
        @(posedge clk); #1;
        wdata = wd; sel0 = 0; sel1 = 0; trans = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready0", 32'(ro0), 1); chk("rst_resp0", 32'(rs0), 0); chk("rst_rdata0", rd0, 0);
        chk("rst_ready1", 32'(ro1), 1); chk("rst_resp1", 32'(rs1), 0); chk("rst_rdata1", rd1, 0);
        reset_n = 1;
        idle(1);
        // word write then back-to-back read, zero waits
        issue(0, 1, 32'h100, 3'd2, 32'h11223344, 0, 0, 0, 0);
        issue(0, 0, 32'h100, 3'd2, 32'h0,        1, 32'h11223344, 0, 0);
        idle(2);
        // byte and half-word lanes
        issue(0, 1, 32'h000, 3'd2, 32'hAABBCCDD, 0, 0, 0, 0);
        issue(0, 1, 32'h003, 3'd0, 32'h55000000, 0, 0, 0, 0);
        issue(0, 1, 32'h000, 3'd1, 32'h00001234, 0, 0, 0, 0);
        idle(1);
        issue(0, 0, 32'h000, 3'd2, 32'h0, 1, 32'h55BB1234, 0, 0);
        issue(0, 1, 32'h002, 3'd1, 32'hBEEF0000, 0, 0, 0, 0);
        idle(1);
        issue(0, 0, 32'h001, 3'd0, 32'h0, 1, 32'hBEEF1234, 0, 0);
        idle(1);
        // forwarding of a full word and of a single lane
        issue(0, 1, 32'h020, 3'd2, 32'h01010101, 0, 0, 0, 0);
        idle(2);
        issue(0, 1, 32'h020, 3'd2, 32'hDEADBEEF, 0, 0, 0, 0);
        issue(0, 0, 32'h020, 3'd2, 32'h0, 1, 32'hDEADBEEF, 0, 0);
        issue(0, 1, 32'h021, 3'd0, 32'h0000AA00, 0, 0, 0, 0);
        issue(0, 0, 32'h020, 3'd2, 32'h0, 1, 32'hDEADAAEF, 0, 0);
        idle(2);
        // three wait states
        issue(1, 1, 32'h040, 3'd2, 32'h0BADF00D, 0, 0, 0, 3);
        issue(1, 0, 32'h040, 3'd2, 32'h0, 1, 32'h0BADF00D, 0, 3);
        idle(6);
        // out-of-range byte write
`ifdef AHB_SRAM_ERROR_RESP_EN
        issue(0, 1, 32'h1000, 3'd0, 32'h00000099, 1, 32'h0, 1, 1);
        issue(0, 0, 32'h0000, 3'd2, 32'h0, 1, 32'hBEEF1234, 0, 0);
`else
        issue(0, 1, 32'h1000, 3'd0, 32'h00000099, 0, 0, 0, 0);
        issue(0, 0, 32'h0000, 3'd2, 32'h0, 1, 32'hBEEF1299, 0, 0);
`endif
        idle(2);
        // reset in the middle of a waited write
        issue(1, 1, 32'h080, 3'd2, 32'hCAFEF00D, 0, 0, 0, 3);
        issue(1, 0, 32'h080, 3'd2, 32'h0, 1, 32'hCAFEF00D, 0, 3);
        issue(1, 1, 32'h080, 3'd2, 32'h0BADBEEF, 0, 0, 0, 3);
        idle(1);
        reset_n = 0;
        #1;
        chk("midrst_ready", 32'(ro1), 1); chk("midrst_resp", 32'(rs1), 0); chk("midrst_rdata", rd1, 0);
        idle(2);
        reset_n = 1;
        idle(1);
        issue(1, 0, 32'h080, 3'd2, 32'h0, 1, 32'hCAFEF00D, 0, 3);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
